dds_multi_channel: RTL

- Parametrised multi-channel direct digital synthesiser; successor to the single-channel DDS generator.
- N_CH phase-coherent channels share one clock. Each channel has its own frequency word, phase word and waveform mode.
- New configuration is written into shadow registers and committed to all channels at once, either immediately or on the next channel-0 phase wrap.
- Feeds parallel offset-binary DAC outputs.

---
 rtl/dds_multi_channel.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dds_multi_channel.sv
// rtl/dds_multi_channel.sv - multi-channel DDS with shadowed config and wrap-synchronous commit
//
// N_CH phase-coherent phase accumulators share one clock. Each channel has a
// frequency word, phase word and waveform mode. Writes go to shadow registers.
// An update pulse copies every shadow to the active set at once: either
// straight away, or (ARMED) on the next channel-0 accumulator carry-out.
//
// Optional build macro: DDS_DITHER_EN. When defined, a shared 16-bit Galois
// LFSR adds 8 bits of dither below the truncation point of every phase.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   cfg_valid    config write request
//   cfg_ready    config write accepted when cfg_valid & cfg_ready (low while ARMED)
//   cfg_chan     target channel; out-of-range values are accepted and dropped
//   cfg_f_word   frequency word (ACC_W bits)
//   cfg_p_word   phase offset word (P_W bits)
//   cfg_mode     00 sine, 01 square, 10 triangle, 11 sawtooth
//   update       single-cycle commit request
//   commit_mode  0 commit now, 1 commit at next channel-0 wrap
//   sync_clr     clear all accumulators
//   data_out     channel k at [k*DW +: DW], unsigned offset binary
//   data_valid   pipeline filled
module dds_multi_channel #(
  parameter int N_CH  = 2,
  parameter int ACC_W = 32,
  parameter int P_W   = 12,
  parameter int DW    = 14
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_chan,
  input  logic [ACC_W-1:0]                            cfg_f_word,
  input  logic [P_W-1:0]                              cfg_p_word,
  input  logic [1:0]                                  cfg_mode,
  input  logic                                        update,
  input  logic                                        commit_mode,
  input  logic                                        sync_clr,
  output logic [N_CH*DW-1:0]                          data_out,
  output logic                                        data_valid
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int QN = 2 ** (P_W - 2);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam logic [1:0] MODE_SINE   = 2'b00;
  localparam logic [1:0] MODE_SQUARE = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  localparam logic [DW-1:0] MAX_VAL = '1;
  localparam logic [DW-1:0] MID_VAL = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-2:0] AMP_VAL = '1;

  logic [0:0]       state;
  logic [0:0]       stateNext;
  logic             commitNow;
  logic             cfgAccept;
  logic [ACC_W:0]   ch0Sum;
  logic             ch0Wrap;
  logic [1:0]       validCnt;

  logic [ACC_W-1:0] acc          [N_CH];
  logic [ACC_W-1:0] fShadow      [N_CH];
  logic [ACC_W-1:0] fShadowNext  [N_CH];
  logic [ACC_W-1:0] fActive      [N_CH];
  logic [P_W-1:0]   pShadow      [N_CH];
  logic [P_W-1:0]   pShadowNext  [N_CH];
  logic [P_W-1:0]   pActive      [N_CH];
  logic [1:0]       modeShadow   [N_CH];
  logic [1:0]       modeShadowNext [N_CH];
  logic [1:0]       modeActive   [N_CH];

  logic [P_W-1:0]   phComb       [N_CH];
  logic [P_W-1:0]   phS1         [N_CH];
  logic [1:0]       modeS1       [N_CH];
  logic [DW-1:0]    waveComb     [N_CH];
  logic [DW-1:0]    waveS2       [N_CH];

  logic [DW-2:0]    sinLut       [QN];

  // Quarter-wave magnitude table, evaluated at elaboration.
  function automatic logic [DW-2:0] sinMag(input int j);
    real amp;
    real x;
    amp = real'((2 ** (DW - 1)) - 1);
    x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(j) / real'(2 ** P_W));
    return (DW-1)'($rtoi(x + 0.5));
  endfunction

  for (genvar j = 0; j < QN; j++) begin : gLut
    assign sinLut[j] = sinMag(j);
  end

  assign cfg_ready = (state == ST_IDLE);
  assign cfgAccept = cfg_valid & cfg_ready;

  // Carry out of the channel-0 accumulation about to happen this edge.
  // A clear on the same edge is not a wrap.
  assign ch0Sum  = {1'b0, acc[0]} + {1'b0, fActive[0]};
  assign ch0Wrap = ch0Sum[ACC_W] & ~sync_clr;

  // Shadow contents after this edge's write, so a commit on the same edge
  // picks up the write.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      fShadowNext[k]    = fShadow[k];
      pShadowNext[k]    = pShadow[k];
      modeShadowNext[k] = modeShadow[k];
      if (cfgAccept && (cfg_chan == CW'(k))) begin
        fShadowNext[k]    = cfg_f_word;
        pShadowNext[k]    = cfg_p_word;
        modeShadowNext[k] = cfg_mode;
      end
    end
  end

  always_comb begin
    commitNow = 1'b0;
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (update) begin
          if (commit_mode) stateNext = ST_ARMED;
          else             commitNow = 1'b1;
        end
      end
      ST_ARMED: begin
        // A second update is the escape path when channel 0 never wraps.
        if (update || ch0Wrap) begin
          commitNow = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      for (int k = 0; k < N_CH; k++) begin
        acc[k]        <= '0;
        fShadow[k]    <= '0;
        pShadow[k]    <= '0;
        modeShadow[k] <= '0;
        fActive[k]    <= '0;
        pActive[k]    <= '0;
        modeActive[k] <= '0;
      end
    end else begin
      state <= stateNext;
      for (int k = 0; k < N_CH; k++) begin
        fShadow[k]    <= fShadowNext[k];
        pShadow[k]    <= pShadowNext[k];
        modeShadow[k] <= modeShadowNext[k];
        if (commitNow) begin
          fActive[k]    <= fShadowNext[k];
          pActive[k]    <= pShadowNext[k];
          modeActive[k] <= modeShadowNext[k];
        end
        // Accumulation uses the pre-commit frequency word.
        if (sync_clr) acc[k] <= '0;
        else          acc[k] <= acc[k] + fActive[k];
      end
    end
  end

`ifdef DDS_DITHER_EN
  logic [15:0]    lfsr;
  logic [P_W+7:0] dith;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Dither sits in the 8 bits just below the truncation point; its carry
  // ripples into the phase but never back into the accumulator.
  always_comb begin
    dith = '0;
    for (int k = 0; k < N_CH; k++) begin
      dith      = acc[k][ACC_W-1 -: P_W+8] + {{P_W{1'b0}}, lfsr[7:0]};
      phComb[k] = dith[P_W+7 -: P_W] + pActive[k];
    end
  end
`else
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      phComb[k] = acc[k][ACC_W-1 -: P_W] + pActive[k];
    end
  end
`endif

  logic [1:0]     quad;
  logic [P_W-3:0] idx;
  logic [P_W-3:0] idxMirror;
  logic [DW-2:0]  mag;
  logic [DW-1:0]  sineVal;
  logic [DW-1:0]  triVal;
  logic [DW-1:0]  sawVal;

  always_comb begin
    quad      = '0;
    idx       = '0;
    idxMirror = '0;
    mag       = '0;
    sineVal   = '0;
    triVal    = '0;
    sawVal    = '0;
    for (int k = 0; k < N_CH; k++) begin
      quad      = phS1[k][P_W-1:P_W-2];
      idx       = phS1[k][P_W-3:0];
      idxMirror = ~idx + 1'b1;
      // Odd quadrants read the table backwards; index 0 there is the
      // quarter-period peak, one past the end of the table.
      if (!quad[0])        mag = sinLut[idx];
      else if (idx == '0)  mag = AMP_VAL;
      else                 mag = sinLut[idxMirror];
      sineVal = quad[1] ? (MID_VAL - {1'b0, mag}) : (MID_VAL + {1'b0, mag});

      triVal = DW'(phS1[k][P_W-2:0]) << (DW - P_W + 1);
      if (phS1[k][P_W-1]) triVal = MAX_VAL - triVal;

      sawVal = DW'(phS1[k]) << (DW - P_W);

      case (modeS1[k])
        MODE_SINE:   waveComb[k] = sineVal;
        MODE_SQUARE: waveComb[k] = phS1[k][P_W-1] ? '0 : MAX_VAL;
        MODE_TRI:    waveComb[k] = triVal;
        default:     waveComb[k] = sawVal;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      validCnt   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        phS1[k]   <= '0;
        modeS1[k] <= '0;
        waveS2[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        phS1[k]                 <= phComb[k];
        modeS1[k]               <= modeActive[k];
        waveS2[k]               <= waveComb[k];
        data_out[k*DW +: DW]    <= waveS2[k];
      end
      // Valid on the third edge after release, then sticky.
      if (!data_valid) begin
        validCnt <= validCnt + 2'd1;
        if (validCnt == 2'd2) data_valid <= 1'b1;
      end
    end
  end

endmodule
